// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: per-channel sample FIFOs fed by a valid/ready sink,
// serialized MSB-first onto dacdat as a slave to the codec's BCLK/DACLRCK.
module i2s_dac_tx #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_channel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bclk,
  input  logic             daclrck,
  output logic             dacdat,
  output logic             underflow,
  input  logic             clear_underflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  logic bclk_meta_q, bclk_sync_q, bclk_hist_q;
  logic lrck_meta_q, lrck_sync_q, lrck_hist_q;
  logic bclk_fall_s, lrck_edge_s, new_ch_s;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW:0]      wr_ptr_q [2];
  logic [AW:0]      rd_ptr_q [2];
  logic [1:0]       full_s, empty_s, push_s, pop_s;
  logic [WIDTH-1:0] head_s;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             dacdat_q;
  logic             underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_hist_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      lrck_hist_q <= 1'b0;
    end else begin
      bclk_meta_q <= bclk;
      bclk_sync_q <= bclk_meta_q;
      bclk_hist_q <= bclk_sync_q;
      lrck_meta_q <= daclrck;
      lrck_sync_q <= lrck_meta_q;
      lrck_hist_q <= lrck_sync_q;
    end
  end

  assign bclk_fall_s = bclk_hist_q & ~bclk_sync_q;
  assign lrck_edge_s = lrck_hist_q ^ lrck_sync_q;
  assign new_ch_s    = lrck_sync_q;

  always_comb begin
    full_s  = 2'b00;
    empty_s = 2'b00;
    for (int c = 0; c < 2; c++) begin
      full_s[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                   (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
    end
  end

  // Ready uses only the registered full flag, so a same-cycle pop cannot open the sink.
  assign in_ready  = in_channel ? ~full_s[1] : ~full_s[0];
  assign push_s[0] = in_valid & in_ready & ~in_channel;
  assign push_s[1] = in_valid & in_ready & in_channel;
  assign pop_s[0]  = lrck_edge_s & ~new_ch_s & ~empty_s[0];
  assign pop_s[1]  = lrck_edge_s & new_ch_s & ~empty_s[1];
  assign head_s    = mem_q[new_ch_s][rd_ptr_q[new_ch_s][AW-1:0]];

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push_s[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push_s[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        end
        if (pop_s[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        end
      end
    end
  end

  // A frame start outranks any bit action; a coincident BCLK fall is spent on the delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (lrck_edge_s && empty_s[new_ch_s]) begin
        underflow_q <= 1'b1;
      end else if (clear_underflow) begin
        underflow_q <= 1'b0;
      end

      if (lrck_edge_s) begin
        shift_q   <= empty_s[new_ch_s] ? '0 : head_s;
        bit_cnt_q <= WIDTH_CNT;
        if (bclk_fall_s) begin
          dacdat_q <= 1'b0;
          state_q  <= ST_SHIFT;
        end else begin
          state_q  <= ST_DELAY;
        end
      end else if (bclk_fall_s) begin
        case (state_q)
          ST_DELAY: begin
            dacdat_q <= 1'b0;
            state_q  <= ST_SHIFT;
          end
          ST_SHIFT: begin
            dacdat_q  <= shift_q[WIDTH-1];
            shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 1'b1;
            if (bit_cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
              state_q <= ST_PAD;
            end
          end
          ST_PAD, ST_IDLE: begin
            dacdat_q <= 1'b0;
          end
          default: begin
            dacdat_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dacdat    = dacdat_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed self-checking bench for i2s_dac_tx: BCLK = 8 clk, frames driven by the bench.
module tb_i2s_dac_tx;

  logic        clk;
  logic        reset;
  logic [23:0] in_data;
  logic        in_channel;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        daclrck;
  logic        dacdat;
  logic        underflow;
  logic        clear_underflow;

  int checks = 0;
  int errors = 0;

  i2s_dac_tx dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_channel(in_channel),
    .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .daclrck(daclrck),
    .dacdat(dacdat), .underflow(underflow), .clear_underflow(clear_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic ch, input logic [23:0] d, input string name);
    @(negedge clk);
    in_channel = ch;
    in_data    = d;
    in_valid   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: in_ready=%b expected 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_ready(input logic ch, input logic exp, input string name);
    in_channel = ch;
    #1;
    checks++;
    if (in_ready !== exp) begin
      errors++;
      $display("FAIL %s: in_ready(ch%0d)=%b expected %b", name, ch, in_ready, exp);
    end
  endtask

  task automatic check_uf(input logic exp, input string name);
    checks++;
    if (underflow !== exp) begin
      errors++;
      $display("FAIL %s: underflow=%b expected %b", name, underflow, exp);
    end
  endtask

  // nbits BCLK periods; daclrck switches to ch on the first fall. Optional push/clear in the frame-start cycle.
  task automatic run_frame(input logic ch, input logic [23:0] word, input int nbits,
                           input logic do_push, input logic [23:0] pdata,
                           input logic do_clear, input string name);
    logic [63:0] cap;
    logic [63:0] exp64;
    cap   = 64'd0;
    exp64 = {1'b0, word, 39'd0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bclk = 1'b0;
      if (i == 0) daclrck = ch;
      if (i == 0 && (do_push || do_clear)) begin
        repeat (2) @(negedge clk);
        if (do_push) begin
          in_channel = ch;
          in_data    = pdata;
          in_valid   = 1'b1;
          #1;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_on_pop: in_ready=%b expected 0", name, in_ready);
          end
        end
        if (do_clear) clear_underflow = 1'b1;
        @(negedge clk);
        clear_underflow = 1'b0;
        if (do_push) begin
          #1;
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after_pop: in_ready=%b expected 1", name, in_ready);
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      cap  = {cap[62:0], dacdat};
      bclk = 1'b1;
      repeat (3) @(negedge clk);
    end
    checks++;
    if (cap !== (exp64 >> (64 - nbits))) begin
      errors++;
      $display("FAIL %s: wire=%h expected %h", name, cap, exp64 >> (64 - nbits));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bclk = 1'b1; daclrck = 1'b0; in_data = 24'd0;
    in_channel = 1'b0; in_valid = 1'b0; clear_underflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dacdat !== 1'b0) begin
      errors++;
      $display("FAIL reset_dacdat: dacdat=%b expected 0", dacdat);
    end
    check_uf(1'b0, "reset_underflow");
    check_ready(1'b0, 1'b1, "reset_ready_l");
    check_ready(1'b1, 1'b1, "reset_ready_r");
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    push(1'b0, 24'h800001, "basic_push_l");
    push(1'b1, 24'h7FFFFE, "basic_push_r");
    run_frame(1'b1, 24'h7FFFFE, 32, 1'b0, 24'd0, 1'b0, "basic_frame_r");
    run_frame(1'b0, 24'h800001, 32, 1'b0, 24'd0, 1'b0, "basic_frame_l");
    check_uf(1'b0, "basic_underflow");
  endtask

  task automatic test_fill();
    push(1'b0, 24'hA5A5A5, "fill_push1");
    push(1'b0, 24'h123456, "fill_push2");
    push(1'b0, 24'hC0FFEE, "fill_push3");
    push(1'b0, 24'h0F0F0F, "fill_push4");
    @(negedge clk);
    check_ready(1'b0, 1'b0, "fill_full_l");
    check_ready(1'b1, 1'b1, "fill_ready_r");
    in_channel = 1'b0; in_data = 24'hDEAD00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    push(1'b1, 24'h5A5A5A, "fill_push_r");
  endtask

  task automatic test_pop_push();
    run_frame(1'b1, 24'h5A5A5A, 32, 1'b0, 24'd0, 1'b0, "poppush_frame_r");
    run_frame(1'b0, 24'hA5A5A5, 32, 1'b1, 24'hFEDCBA, 1'b0, "poppush_frame_l");
    @(negedge clk);
    check_ready(1'b0, 1'b0, "poppush_refull");
    check_uf(1'b0, "poppush_underflow");
  endtask

  task automatic test_shorten();
    push(1'b1, 24'h89ABCD, "short_push_r2");
    run_frame(1'b1, 24'h89ABCD, 13, 1'b0, 24'd0, 1'b0, "short_cut_r");
    run_frame(1'b0, 24'h123456, 32, 1'b0, 24'd0, 1'b0, "short_next_l");
    push(1'b1, 24'h13579B, "short_push_r3");
    run_frame(1'b1, 24'h13579B, 32, 1'b0, 24'd0, 1'b0, "short_frame_r3");
    run_frame(1'b0, 24'hC0FFEE, 32, 1'b0, 24'd0, 1'b0, "short_frame_l3");
    check_uf(1'b0, "short_underflow");
  endtask

  task automatic test_underflow();
    run_frame(1'b1, 24'd0, 32, 1'b0, 24'd0, 1'b0, "uf_empty_r");
    check_uf(1'b1, "uf_set");
    @(negedge clk);
    clear_underflow = 1'b1;
    @(negedge clk);
    clear_underflow = 1'b0;
    check_uf(1'b0, "uf_cleared");
    run_frame(1'b0, 24'h0F0F0F, 32, 1'b0, 24'd0, 1'b0, "uf_frame_l4");
    check_uf(1'b0, "uf_still_clear");
    run_frame(1'b1, 24'd0, 32, 1'b0, 24'd0, 1'b1, "uf_clear_collide");
    check_uf(1'b1, "uf_set_wins");
  endtask

  task automatic test_reset_mid();
    push(1'b0, 24'h654321, "rmid_push_l6");
    push(1'b0, 24'h2468AC, "rmid_push_l7");
    run_frame(1'b0, 24'hFEDCBA, 11, 1'b0, 24'd0, 1'b0, "rmid_partial_l5");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dacdat !== 1'b0) begin
      errors++;
      $display("FAIL rmid_dacdat: dacdat=%b expected 0", dacdat);
    end
    check_ready(1'b0, 1'b1, "rmid_ready_l");
    check_uf(1'b0, "rmid_uf_reset");
    repeat (4) @(negedge clk);
    run_frame(1'b1, 24'd0, 32, 1'b0, 24'd0, 1'b0, "rmid_empty_r");
    check_uf(1'b1, "rmid_uf_set");
    run_frame(1'b0, 24'd0, 32, 1'b0, 24'd0, 1'b0, "rmid_empty_l");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_pop_push();
    test_shorten();
    test_underflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
Audio output end of the mixer stream path. It accepts filtered 24-bit signed samples over a valid/ready stream sink and buffers them per channel. It serializes them onto the codec DAC data line in I2S format, slaved to the codec-supplied BCLK and DACLRCK. It sits after the filter/mixer stage and drives the codec pin directly.

Parameters:
WIDTH, 24, sample width in bits (two's complement, MSB first on the wire)
DEPTH, 4, entries per channel FIFO; power of two, >= 2
AW, 2, log2(DEPTH)

Ports:
clk  in  1  system clock; must be >= 8x BCLK frequency
reset  in  1  synchronous, active-high
in_data  in  WIDTH  sample from upstream stream source
in_channel  in  1  0 = left, 1 = right
in_valid  in  1  in_data/in_channel valid
in_ready  out  1  sink can accept the sample for in_channel
bclk  in  1  codec bit clock, asynchronous to clk
daclrck  in  1  codec DAC frame clock; low = left, high = right
dacdat  out  1  serial DAC data, registered in clk domain
underflow  out  1  sticky: a frame started with its channel FIFO empty
clear_underflow  in  1  clears underflow

Behaviour:
- Reset, synchronous, active-high; clock clk. Effects on the next clk edge: both FIFOs empty; dacdat=0; underflow=0; shifter=0; serializer idle. Synchronizer flops are cleared, so no edge is detected in the first 3 cycles after reset. Reset mid-frame aborts the word, and dacdat stays 0 until the next frame start.
- Sync: bclk and daclrck each pass through 2 flops plus 1 history flop.
  - bclk_fall = hist & ~sync.
  - lrck_edge = hist ^ sync. The new channel equals the synced daclrck value.
- FIFOs: two independent circular buffers, left and right, each DEPTH x WIDTH, with AW+1-bit read/write pointers.
  - full and empty are derived from the registered pointers.
- Sink handshake:
  - in_ready = ~full[in_channel]. It is combinational on in_channel only and never depends on in_valid.
  - Push when in_valid & in_ready.
  - A push and a pop on the same FIFO in the same cycle are both performed, and the count is unchanged.
  - When a FIFO is full and a pop occurs in the same cycle, in_ready stays 0 in that cycle (it uses the registered full), so no push happens.
- Frame start happens on lrck_edge:
  - If the new channel's FIFO is non-empty: pop its head into the shifter.
  - Otherwise: load 0 into the shifter and set underflow.
  - Set state DELAY with bit_cnt = WIDTH. Any word in progress is abandoned.
- Serializer states: IDLE, DELAY, SHIFT, PAD. Transitions happen only on bclk_fall.
  - DELAY: the first bclk_fall at or after the frame start (including a bclk_fall in the same cycle as lrck_edge) drives dacdat=0, then moves to SHIFT. This is the I2S one-bit delay.
  - SHIFT: each bclk_fall drives dacdat = shifter[WIDTH-1], shifts left by 1 and decrements bit_cnt. When bit_cnt reaches 1 on that edge, go to PAD.
  - PAD: dacdat=0 on every bclk_fall until the next frame start.
  - IDLE: the state after reset; dacdat=0.
- lrck_edge has priority over a bclk_fall action in the same cycle. Only the frame-start load plus DELAY consumption occur.
- dacdat changes only in the cycle following a detected bclk_fall, so it is stable around the codec's BCLK rising sample point.
- Latency: MSB appears 2 BCLK falls after the frame start, plus 3-4 clk of sync delay. Frame length (e.g. 32 or 64 BCLKs) is dictated by the codec; bits beyond WIDTH are padded with 0.
- underflow: set on any empty-FIFO frame start. Cleared by clear_underflow; a simultaneous set wins.

Test Plan:
1. Push L=24'h800001 and R=24'h7FFFFE, then run 32-BCLK frames. Wire shows delay 0, then 100000000000000000000001, then 7 zeros on left; right shows 0, 011111111111111111111110, 0 pad. underflow stays 0.
2. Push 4 left samples with no BCLK running. in_ready goes 0 for in_channel=0 after the 4th push and stays 1 for in_channel=1. A 5th left in_valid is not accepted.
3. Full left FIFO; a frame start pops in the same cycle as in_valid=1. No push that cycle; push succeeds next cycle, and the FIFO returns to 4 entries.
4. Empty FIFOs with frames running. dacdat is all 0 and underflow=1. Assert clear_underflow during a non-frame-start cycle -> 0. Assert it coincident with an empty frame start -> stays 1.
5. Assert reset at bit 10 of a word with 2 samples queued. dacdat=0 next cycle and in_ready=1. The next frame underflows, outputs zeros, and sets underflow.
6. Shorten a frame: toggle daclrck after 12 bits. The old word is abandoned, and the new channel's sample starts with delay bit then MSB. No FIFO entry is lost or duplicated.
